// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the MEM-stage data access, and produces the pipeline stall qualifier
// data_ready_mem.
//
// Handshake: mem_valid is raised the cycle after a grant. It stays high, with
// mem_we/mem_addr/mem_wdata stable, until the edge that samples mem_ready=1.
// mem_ready is a one-cycle pulse and mem_rdata is valid in that same cycle.
// if_ack is a one-cycle pulse and if_rdata is valid while it is high.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  // MEM-stage data side
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              alu_ready,
  output logic              data_ready_mem,
  output logic [DATA_W-1:0] d_rdata,
  // unified memory side
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // status / debug
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_done;
  logic              r_drop;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_d_req;
  logic              w_d_pend;
  logic              w_data_ready;
  logic              w_advance;
  logic              w_grant;
  logic              w_wait;
  logic [CNT_W-1:0]  w_cnt_inc;

  // A data access is pending until its result has been captured in d_done;
  // d_done then masks the still-asserted request until the pipeline moves on.
  assign w_d_req      = d_rd | d_wr;
  assign w_d_pend     = w_d_req & ~r_d_done;
  assign w_data_ready = rst | ~w_d_pend;
  assign w_advance    = alu_ready & w_data_ready;

  // Any accepted transaction from IDLE restarts the watchdog.
  assign w_grant   = (r_state == ST_IDLE) & (w_d_pend | if_req);
  assign w_wait    = (r_state != ST_IDLE) & ~mem_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Arbitration FSM: data wins over fetch, a started fetch is never aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_d_done    <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_d_pend) begin
            // d_rd and d_wr together behave as a store
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_we    <= d_wr;
            r_mem_valid <= 1'b1;
            r_state     <= ST_D_BUSY;
          end else if (if_req) begin
            r_mem_addr  <= if_addr;
            r_mem_we    <= 1'b0;
            r_mem_valid <= 1'b1;
            r_drop      <= if_flush;
            r_state     <= ST_IF_BUSY;
          end
        end
        ST_IF_BUSY: begin
          if (mem_ready) begin
            // a flush in the completion cycle also discards the result
            r_if_rdata  <= mem_rdata;
            r_if_ack    <= ~(r_drop | if_flush);
            r_drop      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (if_flush) begin
            r_drop <= 1'b1;
          end
        end
        ST_D_BUSY: begin
          if (mem_ready) begin
            if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
            r_mem_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase

      // d_done marks "result delivered, waiting for the pipeline to advance"
      if ((r_state == ST_D_BUSY) && mem_ready) begin
        r_d_done <= 1'b1;
      end else if (w_advance) begin
        r_d_done <= 1'b0;
      end
    end
  end

  // Watchdog: counts busy cycles without mem_ready, saturates, raises sticky err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (w_wait && (r_cnt != CNT_MAX)) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == CNT_MAX) begin
        r_err <= 1'b1;
      end
    end
  end

  assign data_ready_mem = w_data_ready;
  assign mem_valid      = r_mem_valid;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign if_ack         = r_if_ack;
  assign if_rdata       = r_if_rdata;
  assign d_rdata        = r_d_rdata;
  assign err            = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Expected memory requests, fetch results and load results are queued when
// stimulus is issued; a negedge monitor pops and compares as the DUT presents
// them. A small external memory model answers mem_valid with random latency.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          if_req, if_flush, if_ack;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_rd, d_wr, alu_ready, data_ready_mem;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_valid, mem_we, mem_ready, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .alu_ready(alu_ready), .data_ready_mem(data_ready_mem), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [64:0]   exp_mem_q[$];   // {we, addr, wdata}
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] ref_mem[logic [31:0]];
  logic [DW-1:0] bmem[logic [31:0]];
  logic [DW-1:0] last_load = '0;

  // memory model controls
  int force_lat    = 0;
  bit withhold     = 1'b0;
  bit inject_ready = 1'b0;
  int lat_cnt      = 0;
  int cur_lat      = 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- external memory model ----------------
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (inject_ready) begin
        mem_ready    = 1'b1;
        mem_rdata    = $urandom;
        inject_ready = 1'b0;
      end else if (mem_valid === 1'b1 && !withhold) begin
        if (lat_cnt == 0) cur_lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
        lat_cnt++;
        if (lat_cnt >= cur_lat) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = bmem_rd(mem_addr);
          end
          lat_cnt = 0;
        end
      end else if (mem_valid !== 1'b1) begin
        lat_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  logic prev_drdy  = 1'b1;
  logic prev_ready = 1'b0;
  logic prev_rst   = 1'b1;

  always @(negedge clk) begin
    logic [64:0] em;
    if (!rst) begin
      if (mem_valid && !prev_valid) begin
        if (exp_mem_q.size() == 0) begin
          chk("mem_req_unexpected", {mem_we, mem_addr}, 64'h0);
          if (mem_we === 1'b0 && mem_addr === '0) chk("mem_req_unexpected_flag", 1, 0);
        end else begin
          em = exp_mem_q.pop_front();
          chk("mem_we", mem_we, em[64]);
          chk("mem_addr", mem_addr, em[63:32]);
          if (em[64]) chk("mem_wdata", mem_wdata, em[31:0]);
        end
      end
      if (if_ack) begin
        if (exp_if_q.size() == 0) chk("if_ack_unexpected", if_ack, 0);
        else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if ((d_rd | d_wr) && data_ready_mem && !prev_drdy && !prev_rst) begin
        chk("drdy_after_mem_ready", prev_ready, 1);
        if (exp_d_q.size() == 0) chk("d_done_unexpected", data_ready_mem, 0);
        else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
      if (!(d_rd | d_wr)) chk("drdy_no_request", data_ready_mem, 1);
    end
    prev_valid = mem_valid;
    prev_drdy  = data_ready_mem;
    prev_ready = mem_ready;
    prev_rst   = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_drdy"}, data_ready_mem, 1);
  endtask

  // One MEM-stage data access; returns after the edge where the pipeline advances.
  task automatic data_op(input bit wr, input bit both, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, input bit push_mem);
    logic [31:0] e;
    int n;
    if (push_mem) exp_mem_q.push_back({wr, a, wr ? wd : 32'h0});
    if (wr) begin
      ref_mem[a] = wd;
      e = last_load;
    end else begin
      e = ref_rd(a);
      last_load = e;
    end
    exp_d_q.push_back(e);
    d_rd = !wr || both;
    d_wr = wr;
    d_addr = a;
    d_wdata = wd;
    alu_ready = (hold == 0);
    @(negedge clk);
    chk("drdy_low_on_request", data_ready_mem, 0);
    n = 0;
    while (data_ready_mem !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("data_wait_timeout", n, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("d_rdata_stable", d_rdata, e);
      chk("drdy_held", data_ready_mem, 1);
    end
    alu_ready = 1'b1;
    @(posedge clk); #1;
    d_rd = 1'b0;
    d_wr = 1'b0;
  endtask

  // One fetch; flush_at: -1 none, 0 grant cycle, k in busy cycle k.
  task automatic fetch_op(input logic [31:0] a, input int flush_at, input bit push_mem,
                          output int busy);
    int n;
    if (push_mem) exp_mem_q.push_back({1'b0, a, 32'h0});
    if (flush_at < 0) exp_if_q.push_back(ref_rd(a));
    if_req = 1'b1;
    if_addr = a;
    if_flush = (flush_at == 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(mem_valid === 1'b1 && mem_we === 1'b0 && mem_addr === a) && n < 200);
    if (n >= 200) chk("fetch_grant_timeout", n, 0);
    if_req = 1'b0;
    busy = 1;
    if_flush = (flush_at == 1);
    n = 0;
    while (mem_valid === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_valid === 1'b1) begin
        busy++;
        if_flush = (busy == flush_at);
      end
    end
    if (n >= 200) chk("fetch_done_timeout", n, 0);
    if_flush = 1'b0;
    @(negedge clk);
    chk("if_ack_pulse", if_ack, (flush_at < 0) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int busy;
    int op;
    int fsel;
    int fl;
    logic [31:0] ia, da, wd;
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0; alu_ready = 1;
    ref_mem[32'h40]  = 32'h00A0_0093; bmem[32'h40]  = 32'h00A0_0093;
    ref_mem[32'h100] = 32'hDEAD_BEEF; bmem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single fetch, 3-cycle memory
    force_lat = 3;
    fetch_op(32'h40, -1, 1, busy);
    chk("fetch_busy_cycles", busy, 3);

    // load and fetch in the same cycle: data first
    force_lat = 2;
    exp_mem_q.push_back({1'b0, 32'h100, 32'h0});
    exp_mem_q.push_back({1'b0, 32'h80, 32'h0});
    fork
      data_op(0, 0, 32'h100, 32'h0, 0, 0);
      fetch_op(32'h80, -1, 0, busy);
    join
    repeat (2) @(posedge clk); #1;

    // store arriving during an in-flight fetch waits for it
    force_lat = 4;
    exp_mem_q.push_back({1'b0, 32'h44, 32'h0});
    exp_mem_q.push_back({1'b1, 32'h200, 32'h1234_5678});
    fork
      fetch_op(32'h44, -1, 0, busy);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_op(1, 0, 32'h200, 32'h1234_5678, 0, 0);
      end
    join
    repeat (2) @(posedge clk); #1;

    // load completes while the pipeline is stalled, then back-to-back load
    force_lat = 2;
    data_op(0, 0, 32'h200, 32'h0, 4, 1);
    data_op(0, 0, 32'h104, 32'h0, 0, 1);

    // flushed fetches, then a normal one
    force_lat = 3;
    fetch_op(32'h48, 2, 1, busy);
    chk("flush_fetch_busy", busy, 3);
    fetch_op(32'h4C, 0, 1, busy);
    fetch_op(32'h50, -1, 1, busy);

    // randomized mix
    force_lat = 0;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      ia = 32'(4 * $urandom_range(0, 63));
      da = 32'h100 + 32'(4 * $urandom_range(0, 191));
      wd = $urandom;
      fsel = $urandom_range(0, 3);
      fl = (fsel == 0) ? 0 : (fsel == 1) ? 1 : -1;
      case (op)
        0: fetch_op(ia, fl, 1, busy);
        1: data_op(0, 0, da, 32'h0, $urandom_range(0, 2), 1);
        2: data_op(1, $urandom_range(0, 1), da, wd, $urandom_range(0, 2), 1);
        3: begin
          exp_mem_q.push_back({1'b0, da, 32'h0});
          exp_mem_q.push_back({1'b0, ia, 32'h0});
          fork
            data_op(0, 0, da, 32'h0, $urandom_range(0, 2), 0);
            fetch_op(ia, fl, 0, busy);
          join
        end
        default: begin
          exp_mem_q.push_back({1'b0, ia, 32'h0});
          exp_mem_q.push_back({1'b1, da, wd});
          fork
            fetch_op(ia, fl, 0, busy);
            begin
              @(posedge clk); #1;
              data_op(1, 0, da, wd, 0, 0);
            end
          join
        end
      endcase
      @(posedge clk); #1;
    end

    // watchdog: withheld mem_ready
    withhold = 1'b1;
    exp_mem_q.push_back({1'b0, 32'h300, 32'h0});
    d_rd = 1'b1; d_addr = 32'h300; alu_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("err_watchdog", err, (k >= 8) ? 1 : 0);
      chk("mem_valid_waiting", mem_valid, 1);
      @(posedge clk); #1;
    end

    // reset mid-transaction, then a stray mem_ready in IDLE
    rst = 1'b1;
    d_rd = 1'b0;
    withhold = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = '0;
    inject_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stray_ready_valid", mem_valid, 0);
      chk("stray_ready_d_rdata", d_rdata, 0);
      chk("stray_ready_if_rdata", if_rdata, 0);
      chk("stray_ready_err", err, 0);
    end
    @(posedge clk); #1;

    // normal operation after reset
    force_lat = 1;
    data_op(0, 0, 32'h100, 32'h0, 0, 1);
    fetch_op(32'h40, -1, 1, busy);
    repeat (3) @(posedge clk);
    #1;

    chk("exp_mem_q_empty", exp_mem_q.size(), 0);
    chk("exp_if_q_empty", exp_if_q.size(), 0);
    chk("exp_d_q_empty", exp_d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and the data access of the MEM stage.
- Sequences each access as a req/ready transaction.
- Generates data_ready_mem, the pipeline-wide stall qualifier consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Holds a completed data result until the pipeline actually advances.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 1023, max cycles a transaction may wait for mem_ready before err is set; counter width clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request (level)
if_addr  in  ADDR_W  fetch address (pc_if)
if_flush  in  1  branch taken; discard the in-flight fetch result
if_ack  out  1  one-cycle pulse: if_rdata valid for the granted fetch
if_rdata  out  DATA_W  fetched instruction
d_rd  in  1  memread_mem
d_wr  in  1  memwrite_mem
d_addr  in  ADDR_W  alu_result_mem
d_wdata  in  DATA_W  write_data_memory_mem
alu_ready  in  1  high when no other stall source holds the pipeline
data_ready_mem  out  1  low while a data access is unsatisfied
d_rdata  out  DATA_W  load data (data_from_memory_mem)
mem_valid  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  one-cycle completion pulse; mem_rdata valid
mem_rdata  in  DATA_W  memory read data
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-transaction):
  - state=IDLE; mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ack=0; if_rdata=0; d_rdata=0; err=0; d_done=0; drop=0; counter=0.
  - A mem_ready arriving after reset is ignored in IDLE.
- d_pend = (d_rd | d_wr) & ~d_done.
- data_ready_mem = ~d_pend, combinational.
  - Goes low in the same cycle a new data request appears.
  - Reads 1 during reset.
- d_rd and d_wr both high is treated as a write.
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - If d_pend: latch d_addr, d_wdata and (mem_we=d_wr); go to D_BUSY.
  - Else if if_req: latch if_addr, mem_we=0; go to IF_BUSY.
  - Data always has priority.
  - mem_valid=1 from the cycle after the grant until the cycle mem_ready is sampled.
- IF_BUSY:
  - An in-flight fetch is never aborted; a data request arriving meanwhile waits, with data_ready_mem=0.
  - if_flush=1 in any IF_BUSY cycle, or in the grant cycle, sets drop.
  - On mem_ready: if_rdata<=mem_rdata; if_ack pulses 1 cycle later unless drop; drop cleared; return to IDLE.
- D_BUSY:
  - On mem_ready: d_rdata<=mem_rdata for loads; d_rdata unchanged for stores.
  - Set d_done; return to IDLE.
  - data_ready_mem rises the cycle after mem_ready.
- d_done:
  - Cleared at a posedge where alu_ready=1 and data_ready_mem=1 (the pipeline advances).
  - While d_done=1 the same request is not reissued and d_rdata is held stable.
  - If alu_ready=0, d_done persists indefinitely.
- Back-to-back loads: minimum latency request to data_ready_mem=1 is 2 cycles + memory latency. The next load is granted from IDLE one cycle after d_done clears.
- Watchdog:
  - Counter resets on each grant and increments each busy cycle without mem_ready.
  - At TIMEOUT: err<=1 (sticky until rst). The FSM keeps waiting.
  - Counter saturates.
- mem_addr and mem_wdata hold their last values in IDLE; mem_valid=0 there.

Test Plan:
- Reset, then if_req=1, if_addr=0x40, memory returns 0x00A00093 after 3 cycles -> mem_valid for 3 cycles with mem_addr=0x40, mem_we=0; if_ack=1 one cycle later with if_rdata=0x00A00093; data_ready_mem=1 throughout.
- d_rd=1, d_addr=0x100 with if_req=1 in the same cycle -> data granted first; data_ready_mem=0 until the cycle after mem_ready; d_rdata=mem_rdata (0xDEADBEEF); fetch granted afterwards.
- Fetch in flight, d_wr=1, d_addr=0x200, d_wdata=0x12345678 arrives -> fetch completes first; then mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; data_ready_mem low from the request cycle until completion+1.
- Load completes while alu_ready=0 for 4 cycles -> no second mem_valid; d_rdata stable; data_ready_mem=1; d_done clears on the first alu_ready=1 edge.
- if_flush pulsed during IF_BUSY -> mem_ready consumed, if_ack never pulses, next IDLE grant proceeds normally.
- TIMEOUT=7, mem_ready withheld -> err=1 after 7 busy cycles and stays 1; rst mid-transaction -> all outputs back to reset values, err=0, late mem_ready ignored.
